axi_lite_traffic_master: RTL
============================

Name: axi_lite_traffic_master

Overview:
- Parametrised AXI4-Lite traffic master that generates a programmable write and/or read-back sequence against a slave, then checks the results.
- It succeeds the fixed 4-transaction example master, adding:
  - configurable address stride
  - run modes (write+read, write-only, read-only)
  - BRESP/RRESP checking
  - an error counter with first-failure address capture
  - a per-transaction timeout monitor
- It sits in the AXI-Lite verification environment and drives an AXI-Lite slave register block directly.

Parameters:
- C_M_START_DATA_VALUE, 32'hAA000000: data value for transaction index 0; index i uses START+i.
- C_M_TARGET_SLAVE_BASE_ADDR, 32'h40000000: address of transaction 0.
- C_M_AXI_ADDR_WIDTH, 32: address bus width.
- C_M_AXI_DATA_WIDTH, 32: data bus width (32 or 64).
- C_M_TRANSACTIONS_NUM, 4: transactions per phase (1..1024).
- C_M_ADDR_STRIDE, 4: byte increment between transaction addresses.
- C_M_TIMEOUT_CYCLES, 256: cycles without a handshake before TIMEOUT is flagged.

Ports:
- M_AXI_ACLK  in  1  clock
- M_AXI_ARESETN  in  1  reset; synchronous, active-low
- INIT_AXI_TXN  in  1  start; rising edge triggers a run
- MODE  in  2  0=write then read, 1=write only, 2=read only, 3=treated as 0
- TXN_DONE  out  1  run complete (level)
- ERROR  out  1  sticky; set when ERR_CNT is non-zero
- ERR_CNT  out  16  saturating error count
- ERR_ADDR  out  C_M_AXI_ADDR_WIDTH  address of first error
- TIMEOUT  out  1  sticky timeout flag
- BUSY  out  1  run in progress
- M_AXI_AWADDR/AWPROT/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY, ARADDR/ARPROT/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite master ports at the parameter widths.

Behaviour:
- Clock and reset: one clock, M_AXI_ACLK. Reset M_AXI_ARESETN is synchronous and active-low.
- Reset values:
  - all VALID/READY outputs 0
  - AWADDR/ARADDR/WDATA 0
  - TXN_DONE, ERROR, TIMEOUT, BUSY 0
  - ERR_CNT 0, ERR_ADDR 0
  - FSM in IDLE, index 0
- Reset mid-run aborts immediately, including deasserting VALIDs; the bench also resets the slave.
- Start:
  - INIT_AXI_TXN is registered; a rising edge is detected 1 cycle after the input rises.
  - A start is accepted only in IDLE or DONE; edges during a run are ignored.
  - On acceptance: clear TXN_DONE, ERR_CNT, ERR_ADDR, ERROR, TIMEOUT; set BUSY; index=0.
- FSM: IDLE -> WRITE (mode 0/1/3) or READ (mode 2).
  - WRITE -> READ after the last B handshake (mode 0/3), or -> DONE (mode 1).
  - READ -> DONE after the last R handshake.
  - DONE: TXN_DONE=1, BUSY=0; wait for next start.
- Address and data:
  - Transaction i uses address BASE + i*C_M_ADDR_STRIDE, truncated to the address width, so wrap-around is silent.
  - Expected/write data is START+i at data width, modulo 2^width.
  - WSTRB is all ones, AWPROT=3'b000, ARPROT=3'b001.
- Write transaction (one outstanding):
  - AWVALID and WVALID rise in the same cycle.
  - Each drops the cycle after its own handshake, independently; both handshakes may occur in the same cycle.
  - A VALID is never withdrawn before its handshake.
  - BREADY=1 from issue until B handshake.
  - BRESP!=2'b00 counts as an error.
  - The next transaction issues the cycle after the B handshake.
- Read transaction (one outstanding):
  - ARVALID until handshake; RREADY=1 until R handshake.
  - Error if RRESP!=OKAY or RDATA!=START+i; modes 0, 2 and 3 all compare.
- Error recording:
  - At most one error is counted per transaction; ERR_CNT saturates at 16'hFFFF.
  - ERR_ADDR latches only when ERR_CNT was 0.
  - ERROR = (ERR_CNT!=0), registered.
- Timeout:
  - A counter resets on every issue and every handshake and increments while waiting.
  - When it reaches C_M_TIMEOUT_CYCLES, TIMEOUT is set sticky and ERR_CNT increments once per affected transaction.
  - The handshake keeps waiting per AXI rules; there is no abort.
- Latency: zero-wait slave, write = 3 cycles per transaction, read = 2 cycles.

Test Plan:
1. Mode 0, 4-register slave, defaults, zero wait -> 4 writes to 0x40000000..0x4000000C with data AA000000..AA000003, then 4 matching reads. TXN_DONE=1, ERR_CNT=0, ERROR=0, TIMEOUT=0.
2. Mode 0, slave corrupts readback at index 2 (returns AA000012) -> ERR_CNT=1, ERR_ADDR=0x40000008, ERROR=1, TXN_DONE=1.
3. Mode 1, slave returns BRESP=2'b10 on index 1 and 3 -> no AR activity, ERR_CNT=2, ERR_ADDR=0x40000004.
4. WREADY asserted 1 cycle after WVALID, AWREADY 3 cycles later -> WVALID drops first. Exactly one AW and one W handshake per index; run completes with ERR_CNT=0.
5. Mode 2, slave withholds ARREADY 300 cycles on index 0 -> ARVALID held throughout, TIMEOUT=1 after 256 cycles, ERR_CNT=1. Completion follows once ARREADY arrives.
6. Reset asserted mid-WRITE at index 2, then a new start -> all outputs at reset values the cycle after reset. The new run restarts at index 0 and a second INIT edge during the run is ignored.

Source files
------------

// File: rtl/axi_lite_traffic_master.sv
// AXI4-Lite traffic master: issues a programmable write and/or read-back sequence,
// checks BRESP/RRESP/RDATA, counts errors and flags transactions that stall too long.
module axi_lite_traffic_master #(
    parameter logic [31:0] C_M_START_DATA_VALUE        = 32'hAA000000,
    parameter logic [31:0] C_M_TARGET_SLAVE_BASE_ADDR  = 32'h40000000,
    parameter int          C_M_AXI_ADDR_WIDTH          = 32,
    parameter int          C_M_AXI_DATA_WIDTH          = 32,
    parameter int          C_M_TRANSACTIONS_NUM        = 4,
    parameter int          C_M_ADDR_STRIDE             = 4,
    parameter int          C_M_TIMEOUT_CYCLES          = 256
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESETN,
    input  logic                              INIT_AXI_TXN,
    input  logic [1:0]                        MODE,
    output logic                              TXN_DONE,
    output logic                              ERROR,
    output logic [15:0]                       ERR_CNT,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     ERR_ADDR,
    output logic                              TIMEOUT,
    output logic                              BUSY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam int N  = C_M_TRANSACTIONS_NUM;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = $clog2(C_M_TIMEOUT_CYCLES + 1) + 1;
    localparam logic [TW-1:0] TMO_MAX = TW'(C_M_TIMEOUT_CYCLES);
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ, ST_DONE} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [1:0]      mode_q, mode_d;
    logic            init_q, init_prev_q;
    logic            awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic            arvalid_q, arvalid_d, rready_q, rready_d;
    logic [AW-1:0]   awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            done_q, done_d, busy_q, busy_d, error_q, error_d, timeout_q, timeout_d;
    logic [15:0]     err_cnt_q, err_cnt_d;
    logic [AW-1:0]   err_addr_q, err_addr_d;
    logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic            txn_err_q, txn_err_d;

    logic            start_edge, aw_hs, w_hs, b_hs, ar_hs, r_hs, any_hs, last, err_hit;
    logic [AW-1:0]   cur_addr;

    function automatic logic [AW-1:0] addr_of(input logic [IW-1:0] i);
        addr_of = AW'(C_M_TARGET_SLAVE_BASE_ADDR) + AW'(i) * AW'(C_M_ADDR_STRIDE);
    endfunction

    function automatic logic [DW-1:0] data_of(input logic [IW-1:0] i);
        data_of = DW'(C_M_START_DATA_VALUE) + DW'(i);
    endfunction

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        mode_d     = mode_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        bready_d   = bready_q;
        arvalid_d  = arvalid_q;
        rready_d   = rready_q;
        awaddr_d   = awaddr_q;
        araddr_d   = araddr_q;
        wdata_d    = wdata_q;
        done_d     = done_q;
        busy_d     = busy_q;
        timeout_d  = timeout_q;
        err_cnt_d  = err_cnt_q;
        err_addr_d = err_addr_q;
        tmo_cnt_d  = tmo_cnt_q;
        txn_err_d  = txn_err_q;
        err_hit    = 1'b0;

        start_edge = init_q & ~init_prev_q;
        aw_hs      = awvalid_q & M_AXI_AWREADY;
        w_hs       = wvalid_q & M_AXI_WREADY;
        b_hs       = bready_q & M_AXI_BVALID;
        ar_hs      = arvalid_q & M_AXI_ARREADY;
        r_hs       = rready_q & M_AXI_RVALID;
        any_hs     = aw_hs | w_hs | b_hs | ar_hs | r_hs;
        last       = (idx_q == IDX_LAST);
        cur_addr   = (state_q == ST_READ) ? araddr_q : awaddr_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_edge) begin
                    done_d     = 1'b0;
                    busy_d     = 1'b1;
                    timeout_d  = 1'b0;
                    err_cnt_d  = 16'd0;
                    err_addr_d = '0;
                    tmo_cnt_d  = '0;
                    txn_err_d  = 1'b0;
                    idx_d      = '0;
                    mode_d     = MODE;
                    if (MODE == 2'd2) begin
                        state_d   = ST_READ;
                        arvalid_d = 1'b1;
                        rready_d  = 1'b1;
                        araddr_d  = addr_of('0);
                    end else begin
                        state_d   = ST_WRITE;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        bready_d  = 1'b1;
                        awaddr_d  = addr_of('0);
                        wdata_d   = data_of('0);
                    end
                end
            end
            ST_WRITE: begin
                if (aw_hs) awvalid_d = 1'b0;
                if (w_hs)  wvalid_d  = 1'b0;
                if (b_hs) begin
                    bready_d  = 1'b0;
                    txn_err_d = 1'b0;
                    if ((M_AXI_BRESP != 2'b00) && !txn_err_q) err_hit = 1'b1;
                    if (!last) begin
                        idx_d     = idx_q + 1'b1;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        bready_d  = 1'b1;
                        awaddr_d  = addr_of(idx_q + 1'b1);
                        wdata_d   = data_of(idx_q + 1'b1);
                    end else if (mode_q == 2'd1) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d   = ST_READ;
                        idx_d     = '0;
                        arvalid_d = 1'b1;
                        rready_d  = 1'b1;
                        araddr_d  = addr_of('0);
                    end
                end
            end
            ST_READ: begin
                if (ar_hs) arvalid_d = 1'b0;
                if (r_hs) begin
                    rready_d  = 1'b0;
                    txn_err_d = 1'b0;
                    if (((M_AXI_RRESP != 2'b00) || (M_AXI_RDATA != data_of(idx_q))) && !txn_err_q)
                        err_hit = 1'b1;
                    if (!last) begin
                        idx_d     = idx_q + 1'b1;
                        arvalid_d = 1'b1;
                        rready_d  = 1'b1;
                        araddr_d  = addr_of(idx_q + 1'b1);
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Stall watchdog: a transaction that times out is counted once, then waits on.
        if ((state_q == ST_WRITE) || (state_q == ST_READ)) begin
            if (any_hs) begin
                tmo_cnt_d = '0;
            end else if (tmo_cnt_q == TMO_MAX) begin
                timeout_d = 1'b1;
                if (!txn_err_q) begin
                    err_hit   = 1'b1;
                    txn_err_d = 1'b1;
                end
            end else begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
        end

        if (err_hit) begin
            if (err_cnt_q == 16'd0)     err_addr_d = cur_addr;
            if (err_cnt_q != 16'hFFFF)  err_cnt_d  = err_cnt_q + 16'd1;
        end
        error_d = (err_cnt_d != 16'd0);
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            mode_q      <= 2'd0;
            init_q      <= 1'b0;
            init_prev_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            error_q     <= 1'b0;
            timeout_q   <= 1'b0;
            err_cnt_q   <= 16'd0;
            err_addr_q  <= '0;
            tmo_cnt_q   <= '0;
            txn_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            mode_q      <= mode_d;
            init_q      <= INIT_AXI_TXN;
            init_prev_q <= init_q;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            awaddr_q    <= awaddr_d;
            araddr_q    <= araddr_d;
            wdata_q     <= wdata_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            error_q     <= error_d;
            timeout_q   <= timeout_d;
            err_cnt_q   <= err_cnt_d;
            err_addr_q  <= err_addr_d;
            tmo_cnt_q   <= tmo_cnt_d;
            txn_err_q   <= txn_err_d;
        end
    end

    assign TXN_DONE      = done_q;
    assign ERROR         = error_q;
    assign ERR_CNT       = err_cnt_q;
    assign ERR_ADDR      = err_addr_q;
    assign TIMEOUT       = timeout_q;
    assign BUSY          = busy_q;
    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARPROT  = 3'b001;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule
